// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shift opcodes and bit-reversal helper shared by shift clients
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    SHOP_SRL = 2'b00,
    SHOP_SRA = 2'b01,
    SHOP_SLL = 2'b10,
    SHOP_RSV = 2'b11
  } shift_op_t;

  localparam int DATA_W = 32;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_right32.sv
// ============================================================================
// Module      : shift_right32
// Description : 32-bit logarithmic right barrel shifter, logical or arithmetic
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_right32 (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  input  logic        i_mode,
  output logic [31:0] o_result
);

  logic        w_fill;
  logic [31:0] w_s;

  // i_mode selects sign fill; otherwise vacated bits are zero
  assign w_fill = i_mode & i_data[31];

  always_comb begin
    w_s = i_data;
    if (i_shamt[0]) w_s = {w_fill, w_s[31:1]};
    if (i_shamt[1]) w_s = {{2{w_fill}}, w_s[31:2]};
    if (i_shamt[2]) w_s = {{4{w_fill}}, w_s[31:4]};
    if (i_shamt[3]) w_s = {{8{w_fill}}, w_s[31:8]};
    if (i_shamt[4]) w_s = {{16{w_fill}}, w_s[31:16]};
  end

  assign o_result = w_s;

endmodule

`default_nettype wire

// File: rtl/shift_arbiter2.sv
// ============================================================================
// Module      : shift_arbiter2
// Description : Round-robin two-port arbiter sharing one right shifter, with
//               left shifts formed by bit reversal and a registered response
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_arbiter2
  import shift_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [4:0]       req0_shamt,
  input  logic [1:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [4:0]       req1_shamt,
  input  logic [1:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag
);

  logic             r_last_grant;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_id;
  logic [TAG_W-1:0] r_rsp_tag;

  logic             w_can_accept;
  logic             w_grant;
  logic             w_fire;
  logic [31:0]      w_x;
  logic [4:0]       w_s;
  shift_op_t        w_op;
  logic [TAG_W-1:0] w_tag;
  logic             w_is_sll;
  logic             w_mode;
  logic [31:0]      w_pre;
  logic [31:0]      w_shr;
  logic [31:0]      w_result;

  // Draining and loading in one cycle keeps full throughput
  assign w_can_accept = ~r_rsp_valid | rsp_ready;
  assign w_grant      = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign req0_ready   = w_can_accept & ~w_grant;
  assign req1_ready   = w_can_accept & w_grant;
  assign w_fire       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign w_x   = w_grant ? req1_data  : req0_data;
  assign w_s   = w_grant ? req1_shamt : req0_shamt;
  assign w_op  = shift_op_t'(w_grant ? req1_op : req0_op);
  assign w_tag = w_grant ? req1_tag   : req0_tag;

  // Left shift = reverse, logical right shift, reverse back; reserved acts as srl
  assign w_is_sll = (w_op == SHOP_SLL);
  assign w_mode   = (w_op == SHOP_SRA);
  assign w_pre    = w_is_sll ? rev32(w_x) : w_x;

  shift_right32 u_shift_right32 (
    .i_data   (w_pre),
    .i_shamt  (w_s),
    .i_mode   (w_mode),
    .o_result (w_shr)
  );

  assign w_result = w_is_sll ? rev32(w_shr) : w_shr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_tag    <= '0;
    end else if (w_fire) begin
      r_last_grant <= w_grant;
      r_rsp_valid  <= 1'b1;
      r_rsp_data   <= w_result;
      r_rsp_id     <= w_grant;
      r_rsp_tag    <= w_tag;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_tag   = r_rsp_tag;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter2.sv
// ============================================================================
// Module      : tb_shift_arbiter2
// Description : Scoreboard bench for shift_arbiter2 with a reference shift model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_arbiter2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_op, req1_op;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;

  always #5 clk = ~clk;

  shift_arbiter2 #(.TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_op    (req0_op),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_op    (req1_op),
    .req1_tag   (req1_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag)
  );

  typedef struct packed {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s,
                                            input logic [1:0] op);
    case (op)
      2'b01:   return 32'($signed(x) >>> s);
      2'b10:   return x << s;
      default: return x >> s;
    endcase
  endfunction

  // Reference model evaluated mid-cycle, when inputs are settled for the next edge
  logic m_valid, m_last, m_ca, m_g, m_fire;
  exp_t m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_last  = 1'b1;
      q.delete();
      check("rst_valid", 64'(rsp_valid), 64'(0));
    end else begin
      m_ca = !m_valid || rsp_ready;
      m_g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
      check("req0_ready", 64'(req0_ready), 64'(m_ca && !m_g));
      check("req1_ready", 64'(req1_ready), 64'(m_ca && m_g));
      check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      if (m_valid) begin
        if (q.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
        end else begin
          check("rsp_fields", 64'({rsp_id, rsp_tag, rsp_data}), 64'(q[0]));
          if (rsp_ready) void'(q.pop_front());
        end
      end
      m_fire = m_ca && (req0_valid || req1_valid);
      if (m_fire) begin
        m_last   = m_g;
        m_e.id   = m_g;
        m_e.tag  = m_g ? req1_tag : req0_tag;
        m_e.data = m_g ? ref_shift(req1_data, req1_shamt, req1_op)
                       : ref_shift(req0_data, req0_shamt, req0_op);
        q.push_back(m_e);
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic send1(input bit p, input logic [31:0] d, input logic [4:0] s,
                       input logic [1:0] op, input logic [3:0] t, input logic [31:0] exp);
    if (p) begin
      req1_valid = 1'b1; req1_data = d; req1_shamt = s; req1_op = op; req1_tag = t;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_shamt = s; req0_op = op; req0_tag = t;
    end
    @(posedge clk); #1;
    idle();
    check("dir_valid", 64'(rsp_valid), 64'(1));
    check("dir_data", 64'(rsp_data), 64'(exp));
    check("dir_id", 64'(rsp_id), 64'(p));
    check("dir_tag", 64'(rsp_tag), 64'(t));
  endtask

  logic [36:0] held;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_data = 0; req0_shamt = 0; req0_op = 0; req0_tag = 0;
    req1_valid = 0; req1_data = 0; req1_shamt = 0; req1_op = 0; req1_tag = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fields", 64'({rsp_valid, rsp_id, rsp_tag, rsp_data}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    send1(1'b0, 32'h8000_0000, 5'd4,  2'b00, 4'h3, 32'h0800_0000);
    send1(1'b1, 32'h8000_0000, 5'd31, 2'b01, 4'h5, 32'hFFFF_FFFF);
    send1(1'b1, 32'h0000_0001, 5'd31, 2'b10, 4'h6, 32'h8000_0000);
    send1(1'b1, 32'h7FFF_FFFF, 5'd0,  2'b01, 4'h7, 32'h7FFF_FFFF);
    send1(1'b0, 32'h1234_5678, 5'd0,  2'b11, 4'h8, 32'h1234_5678);

    // Contended: last grant was port 0, so port 1 goes first here
    req0_valid = 1; req0_tag = 4'hA; req0_op = 2'b10; req0_shamt = 5'd1;
    req1_valid = 1; req1_tag = 4'hB; req1_op = 2'b00; req1_shamt = 5'd1;
    for (int i = 0; i < 6; i++) begin
      req0_data = $urandom; req1_data = $urandom;
      @(posedge clk); #1;
      check("ctd_valid", 64'(rsp_valid), 64'(1));
      check("ctd_id", 64'(rsp_id), 64'((i % 2 == 0) ? 1 : 0));
      check("ctd_tag", 64'(rsp_tag), 64'((i % 2 == 0) ? 4'hB : 4'hA));
    end

    // Backpressure with both ports still valid
    rsp_ready = 1'b0;
    #1;
    held = {rsp_id, rsp_tag, rsp_data};
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", 64'({req0_ready, req1_ready}), 64'(0));
      @(posedge clk); #1;
      check("bp_hold", 64'({rsp_id, rsp_tag, rsp_data}), 64'(held));
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req0_ready ^ req1_ready), 64'(1));
    @(posedge clk); #1;
    check("bp_refill", 64'(rsp_valid), 64'(1));
    idle();

    // Reset while a response is pending
    req0_valid = 1; req0_tag = 4'h2;
    @(posedge clk); #1;
    idle(); rsp_ready = 1'b0;
    check("pre_rst_valid", 64'(rsp_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_fields", 64'({rsp_valid, rsp_id, rsp_tag, rsp_data}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1; req0_tag = 4'h4; req1_valid = 1; req1_tag = 4'h9;
    @(posedge clk); #1;
    check("post_rst_grant", 64'(rsp_id), 64'(0));
    idle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      req0_data = $urandom; req0_shamt = 5'($urandom); req0_op = 2'($urandom); req0_tag = 4'($urandom);
      req1_data = $urandom; req1_shamt = 5'($urandom); req1_op = 2'($urandom); req1_tag = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    idle(); rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(q.size()), 64'(0));
    check("final_valid", 64'(rsp_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_arbiter2.md
# shift_arbiter2

Two-port arbiter and sequencer for the shared 32-bit barrel shifter in the ALU. Two requesters, the integer ALU issue path (port 0) and the load/store byte-align path (port 1), present shift operations over valid/ready handshakes. The block grants one request per cycle round-robin, drives the shared right-shifter, and forms left shifts by bit-reversal around it. Each result is returned through a single registered response port carrying the requester ID and tag.

## Interface
- TAG_W, 4, width of the per-request tag echoed on the response
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle when high with req0_valid
- req0_data  in  32  port 0 operand
- req0_shamt  in  5  port 0 shift amount
- req0_op  in  2  port 0 operation: 00 srl, 01 sra, 10 sll, 11 reserved
- req0_tag  in  TAG_W  port 0 tag
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op, req1_tag: same as port 0, for port 1
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts response this cycle
- rsp_data  out  32  shifted result
- rsp_id  out  1  granted port of this result (0 or 1)
- rsp_tag  out  TAG_W  tag of the granted request

## Operation
- Decision: clk and rst_n form the single clock domain; rst_n asserts asynchronously (active-low) and releases synchronously to clk.
- can_accept = !rsp_valid | rsp_ready.
- Arbitration is combinational on the current valids and the last_grant register:
  - One valid: that port is granted.
  - Both valid: the port != last_grant is granted.
- reqN_ready = can_accept & grant==N. A port is never ready without being granted. reqN_ready may depend on the other port's valid.
- Fire = (req0_valid & req0_ready) | (req1_valid & req1_ready).
- On fire:
  - last_grant is set to the granted port.
  - The response register loads the result, the granted port's ID, and its tag.
  - rsp_valid is set to 1.
- On rsp_valid & rsp_ready without fire: rsp_valid clears to 0.
- Datapath for the granted request, with x = data and s = shamt:
  - srl: x >> s, zero fill.
  - sra: x >> s, fill with x[31].
  - sll: rev(rev(x) >> s) with mode = logical, where rev is 32-bit bit reversal.
  - op 11: treated as srl. No error is flagged.
  - shamt = 0 returns x unchanged for every op.
- Response fields (rsp_data, rsp_id, rsp_tag) hold stable while rsp_valid & !rsp_ready.
- Requester inputs need not hold stable after acceptance.

## Timing
- Reset values: rsp_valid 0, rsp_data 0, rsp_id 0, rsp_tag 0. last_grant resets to 1, so port 0 wins the first contended cycle.
- Latency: a request accepted in cycle N produces rsp_valid in cycle N+1.
- Throughput: 1 result per cycle while rsp_ready stays high. Accept and drain in the same cycle are required; no bubble is allowed.
- Contended steady state with rsp_ready high: grants alternate 0,1,0,1. The maximum wait for a valid port is 1 grant.
- Backpressure: with rsp_valid=1 and rsp_ready=0, both readys are 0 and the register holds.
- A valid deasserted before acceptance is simply not granted. No state changes.
- Reset mid-operation: a pending response is discarded, rsp_valid returns to 0 immediately, and last_grant returns to 1.

## Structure
- Shared package shift_pkg holds:
  - SHOP_SRL=2'b00, SHOP_SRA=2'b01, SHOP_SLL=2'b10, SHOP_RSV=2'b11.
  - The 2-bit shift_op typedef.
  - A rev32 function, to be reused by other shift clients.
- One sub-module instance: shift_right32 (existing right barrel shifter), shared by both ports. Its mode input is 1 only for SHOP_SRA.
- Arbiter, operand muxing, pre/post bit-reversal and the response register live in shift_arbiter2.

## Test plan
- Reset: assert rst_n=0 mid-stream with rsp_valid=1 -> rsp_valid=0 and all rsp_* = 0 immediately. After release, the first contended grant goes to port 0.
- Single port 0, op srl, data 0x80000000, shamt 4, tag 0x3 -> next cycle rsp_data=0x08000000, rsp_id=0, rsp_tag=0x3.
- Port 1, op sra, data 0x80000000, shamt 31 -> rsp_data=0xFFFFFFFF. Then op sll, data 0x00000001, shamt 31 -> rsp_data=0x80000000. Then op sra, data 0x7FFFFFFF, shamt 0 -> rsp_data=0x7FFFFFFF.
- Both ports valid for 6 cycles with rsp_ready=1 -> 6 back-to-back responses, rsp_id sequence 0,1,0,1,0,1, and each tag matches its port.
- Hold rsp_ready=0 for 3 cycles with both ports valid -> req0_ready=req1_ready=0, and rsp_data/id/tag stay stable. When rsp_ready rises, the held response drains and a new grant fires in the same cycle.
- Randomized ops/shamt on both ports (op 11 included, compared as srl) -> every response matches the reference shift model, with no loss, duplication or reordering per port.
